rc_cpl_depacketizer: RTL and testbench
======================================

# rc_cpl_depacketizer

Receive-side stage directly downstream of the requester-completion (RC) adapter on the 128-bit UltraScale+ PCIe PHY path. It consumes the legacy-format completion stream, where beat 0 carries the 3-DW completion header plus the first payload DW. It latches the header fields as sideband and re-aligns the payload so payload DW0 lands in bits [31:0] of the first output beat. Completion length, poison and discontinue status are checked here and reported once per packet to the DMA reader.

## Interface
- DATA_WIDTH, 128: stream width in bits; only 128 is supported.
- user_clk  in  1  clock for all logic.
- user_reset_n  in  1  synchronous, active-low reset.
- s_tvalid  in  1  input beat valid.
- s_tready  out  1  input beat accepted when high together with s_tvalid.
- s_tdata  in  128  input beat.
  - Beat 0, header DW0 [31:0]: len [9:0], attr [13:12], tc [22:20], fmt/type [31:24].
  - Beat 0, header DW1 [63:32]: byte_count [43:32], status [47:45], completer_id [63:48].
  - Beat 0, header DW2 [95:64]: lower_addr [70:64], tag [79:72], requester_id [95:80].
  - Beat 0, payload DW0 [127:96].
- s_tkeep  in  16  byte enables; ignored (payload extent comes from len).
- s_tlast  in  1  last input beat.
- s_tuser  in  85  bit 14 = sop, bit 1 = poisoned, bit 0 = discontinue; other bits ignored.
- m_tvalid  out  1  output beat valid.
- m_tready  in  1  downstream ready.
- m_tdata  out  128  realigned payload.
- m_tdwen  out  4  per-DW enables, bit i covers [32i+31:32i].
- m_tfirst  out  1  first beat of a completion.
- m_tlast  out  1  last beat of a completion.
- m_terr  out  1  on the m_tlast beat: poisoned, or discontinue seen, or length mismatch.
- cpl_tag  out  8  latched header field; stable from the m_tfirst beat through the m_tlast beat.
- cpl_len  out  10  latched header field; same stability as cpl_tag.
- cpl_byte_count  out  12  latched header field; same stability as cpl_tag.
- cpl_lower_addr  out  7  latched header field; same stability as cpl_tag.
- cpl_status  out  3  latched header field; same stability as cpl_tag.
- cpl_cmp_id  out  16  latched header field; same stability as cpl_tag.

## Operation
- States:
  - IDLE: waiting for a beat with sop.
  - BODY: consuming payload beats.
  - FLUSH: emitting the final carry-only beat.
- Length: rem is 11 bits and counts payload DWs not yet emitted. It loads len on sop, with len = 0 meaning 1024.
- Completion without data (fmt[1] = 0), accepted in IDLE:
  - Emit one beat: m_tfirst = m_tlast = 1, m_tdwen = 0.
  - m_terr = poisoned | discontinue.
  - Stay in IDLE.
- Data completion, beat 0 in IDLE:
  - Latch header fields and carry = s_tdata[127:96]; err = poisoned | discontinue.
  - No output beat is produced.
  - If s_tlast: len = 1 goes to FLUSH; any other len sets err and goes to FLUSH.
  - Otherwise go to BODY.
- BODY beat accepted:
  - Output m_tdata = {s_tdata[95:0], carry}.
  - m_tdwen = 4'b1111 if rem ≥ 4, else the low rem bits set.
  - Then carry ← s_tdata[127:96], rem ← rem − min(rem, 4).
  - err |= discontinue.
- End of packet:
  - If rem reaches 0 on this beat, m_tlast = 1.
  - s_tlast with rem still > 0 after the beat goes to FLUSH (normal case len mod 4 = 1).
  - s_tlast with rem = 0 returns to IDLE.
  - rem = 0 without s_tlast sets err; further beats are dropped until s_tlast, and IDLE follows.
- FLUSH emits {96'h0, carry} with m_tdwen = 4'b0001 and m_tlast = 1. It emits an error-only last beat (m_tdwen = 0, m_terr = 1) if rem ≠ 1. Return to IDLE.
- m_tfirst is set on the first output beat after sop.
- A beat without sop in IDLE is dropped (s_tready = 1).
- m_terr = err at the m_tlast beat, else 0.

## Timing
- Single output register.
- s_tready = (state ≠ FLUSH) & (!m_tvalid | m_tready).
- Latency: an output beat is valid the cycle after the input beat that completes it. A FLUSH beat is valid one cycle after the tlast beat's output is accepted.
- Throughput: one beat per clock with m_tready held high. A packet with len mod 4 = 1 costs one extra cycle.
- Output stability: while m_tvalid & !m_tready, every m_* and cpl_* output holds.
- Reset values: m_tvalid = 0, m_tfirst = 0, m_tlast = 0, m_terr = 0, m_tdwen = 0, state = IDLE, rem = 0, err = 0. Data and cpl_* fields reset to 0.
- Reset mid-packet discards the partial completion. No output is emitted afterwards until a beat with sop.

## Test plan
- len = 1, single beat, DW0 = 0xA5A5A5A5 -> one beat: m_tdata[31:0] = 0xA5A5A5A5, m_tdwen = 0001, first = last = 1, m_terr = 0, cpl_tag as sent.
- len = 4, input beats 0..1 -> one output beat, tdwen = 1111, DW0..3 = sent payload in order, first = last = 1.
- len = 5 -> two beats (1111, then FLUSH 0001), last on the second beat, one bubble cycle; len = 1024 (len field 0) -> 256 beats, last tdwen = 1111.
- len = 8 with m_tready toggling 1010… -> output sequence identical to ready = 1, no lost or duplicated DW, outputs stable under stall.
- Poisoned data completion len = 2, and a len = 3 packet whose tlast arrives one beat early -> both deliver a last beat with m_terr = 1; next clean packet has m_terr = 0.
- No-data completion (fmt = 000) -> single beat tdwen = 0000, first = last = 1. Reset asserted during BODY -> m_tvalid = 0 next cycle, next packet correct.

Source files
------------

// File: rtl/rc_cpl_depacketizer.sv
// Requester-completion depacketizer: strips the 3-DW header, realigns the payload so DW0 sits in
// bits [31:0], latches header sideband and flags poison/discontinue/length errors on the last beat.
module rc_cpl_depacketizer #(
   parameter int DATA_WIDTH = 128
) (
   input  logic                  user_clk,
   input  logic                  user_reset_n,
   input  logic                  s_tvalid,
   output logic                  s_tready,
   input  logic [DATA_WIDTH-1:0] s_tdata,
   input  logic [15:0]           s_tkeep,
   input  logic                  s_tlast,
   input  logic [84:0]           s_tuser,
   output logic                  m_tvalid,
   input  logic                  m_tready,
   output logic [DATA_WIDTH-1:0] m_tdata,
   output logic [3:0]            m_tdwen,
   output logic                  m_tfirst,
   output logic                  m_tlast,
   output logic                  m_terr,
   output logic [7:0]            cpl_tag,
   output logic [9:0]            cpl_len,
   output logic [11:0]           cpl_byte_count,
   output logic [6:0]            cpl_lower_addr,
   output logic [2:0]            cpl_status,
   output logic [15:0]           cpl_cmp_id
);

   typedef enum logic [1:0] {IDLE = 2'd0, BODY = 2'd1, FLUSH = 2'd2} state_t;

   state_t       state, state_nxt;
   logic [10:0]  rem, rem_nxt, take, rem_after, len_dw;
   logic [31:0]  carry, carry_nxt;
   logic         err, err_nxt, first_pend, first_nxt;
   logic         hdr_ld, emit, slot_free, acc, sop, poison, disc;
   logic [127:0] o_dat;
   logic [3:0]   o_dwen, dwen_body;
   logic         o_first, o_last, o_err;
   logic         unused_ok;

   // tkeep and most tuser/header bits carry nothing this stage needs
   assign unused_ok = ^{s_tkeep, s_tuser, s_tdata};

   assign slot_free = !m_tvalid || m_tready;
   assign s_tready  = (state != FLUSH) && slot_free;
   assign acc       = s_tvalid && s_tready;
   assign sop       = s_tuser[14];
   assign poison    = s_tuser[1];
   assign disc      = s_tuser[0];
   assign len_dw    = (s_tdata[9:0] == 10'd0) ? 11'd1024 : {1'b0, s_tdata[9:0]};
   assign take      = (rem >= 11'd4) ? 11'd4 : rem;
   assign rem_after = rem - take;

   always_comb begin
      dwen_body = 4'b1111;
      if (rem < 11'd4) begin
         case (rem[1:0])
            2'd0:    dwen_body = 4'b0000;
            2'd1:    dwen_body = 4'b0001;
            2'd2:    dwen_body = 4'b0011;
            default: dwen_body = 4'b0111;
         endcase
      end
   end

   always_comb begin
      state_nxt = state;
      rem_nxt   = rem;
      err_nxt   = err;
      carry_nxt = carry;
      first_nxt = first_pend;
      hdr_ld    = 1'b0;
      emit      = 1'b0;
      o_dat     = '0;
      o_dwen    = 4'b0000;
      o_first   = 1'b0;
      o_last    = 1'b0;
      o_err     = 1'b0;
      case (state)
         IDLE: begin
            if (acc && sop) begin
               hdr_ld = 1'b1;
               if (!s_tdata[30]) begin
                  emit    = 1'b1;
                  o_first = 1'b1;
                  o_last  = 1'b1;
                  o_err   = poison | disc;
               end else begin
                  carry_nxt = s_tdata[127:96];
                  err_nxt   = poison | disc;
                  rem_nxt   = len_dw;
                  first_nxt = 1'b1;
                  if (s_tlast) begin
                     state_nxt = FLUSH;
                     if (len_dw != 11'd1) err_nxt = 1'b1;
                  end else begin
                     state_nxt = BODY;
                  end
               end
            end
         end
         BODY: begin
            if (acc) begin
               // rem == 0 here means the packet overran its length: drain to tlast
               if (rem == 11'd0) begin
                  if (s_tlast) state_nxt = IDLE;
               end else begin
                  emit      = 1'b1;
                  o_dat     = {s_tdata[95:0], carry};
                  o_dwen    = dwen_body;
                  o_first   = first_pend;
                  first_nxt = 1'b0;
                  carry_nxt = s_tdata[127:96];
                  rem_nxt   = rem_after;
                  err_nxt   = err | disc;
                  if (rem_after == 11'd0) begin
                     o_last = 1'b1;
                     if (s_tlast) begin
                        state_nxt = IDLE;
                        o_err     = err | disc;
                     end else begin
                        err_nxt = 1'b1;
                        o_err   = 1'b1;
                     end
                  end else if (s_tlast) begin
                     state_nxt = FLUSH;
                  end
               end
            end
         end
         FLUSH: begin
            if (slot_free) begin
               emit      = 1'b1;
               o_last    = 1'b1;
               o_first   = first_pend;
               first_nxt = 1'b0;
               if (rem == 11'd1) begin
                  o_dat  = {96'h0, carry};
                  o_dwen = 4'b0001;
                  o_err  = err;
               end else begin
                  o_err  = 1'b1;
               end
               rem_nxt   = 11'd0;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge user_clk) begin
      if (!user_reset_n) begin
         state          <= IDLE;
         rem            <= '0;
         err            <= 1'b0;
         carry          <= '0;
         first_pend     <= 1'b0;
         m_tvalid       <= 1'b0;
         m_tdata        <= '0;
         m_tdwen        <= '0;
         m_tfirst       <= 1'b0;
         m_tlast        <= 1'b0;
         m_terr         <= 1'b0;
         cpl_tag        <= '0;
         cpl_len        <= '0;
         cpl_byte_count <= '0;
         cpl_lower_addr <= '0;
         cpl_status     <= '0;
         cpl_cmp_id     <= '0;
      end else begin
         state      <= state_nxt;
         rem        <= rem_nxt;
         err        <= err_nxt;
         carry      <= carry_nxt;
         first_pend <= first_nxt;
         if (slot_free) m_tvalid <= emit;
         if (emit) begin
            m_tdata  <= o_dat;
            m_tdwen  <= o_dwen;
            m_tfirst <= o_first;
            m_tlast  <= o_last;
            m_terr   <= o_err;
         end
         if (hdr_ld) begin
            cpl_tag        <= s_tdata[79:72];
            cpl_len        <= s_tdata[9:0];
            cpl_byte_count <= s_tdata[43:32];
            cpl_lower_addr <= s_tdata[70:64];
            cpl_status     <= s_tdata[47:45];
            cpl_cmp_id     <= s_tdata[63:48];
         end
      end
   end

endmodule

// File: tb/tb_rc_cpl_depacketizer.sv
// Directed bench for rc_cpl_depacketizer: packets from a small table, expected beats built by hand-rules.
module tb_rc_cpl_depacketizer;

   logic         user_clk = 1'b0;
   logic         user_reset_n = 1'b0;
   logic         s_tvalid = 1'b0;
   logic         s_tready;
   logic [127:0] s_tdata = '0;
   logic [15:0]  s_tkeep = '0;
   logic         s_tlast = 1'b0;
   logic [84:0]  s_tuser = '0;
   logic         m_tvalid;
   logic         m_tready;
   logic [127:0] m_tdata;
   logic [3:0]   m_tdwen;
   logic         m_tfirst, m_tlast, m_terr;
   logic [7:0]   cpl_tag;
   logic [9:0]   cpl_len;
   logic [11:0]  cpl_byte_count;
   logic [6:0]   cpl_lower_addr;
   logic [2:0]   cpl_status;
   logic [15:0]  cpl_cmp_id;

   rc_cpl_depacketizer #(.DATA_WIDTH(128)) dut (
      .user_clk(user_clk), .user_reset_n(user_reset_n),
      .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tkeep(s_tkeep),
      .s_tlast(s_tlast), .s_tuser(s_tuser),
      .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tdwen(m_tdwen),
      .m_tfirst(m_tfirst), .m_tlast(m_tlast), .m_terr(m_terr),
      .cpl_tag(cpl_tag), .cpl_len(cpl_len), .cpl_byte_count(cpl_byte_count),
      .cpl_lower_addr(cpl_lower_addr), .cpl_status(cpl_status), .cpl_cmp_id(cpl_cmp_id)
   );

   always #5 user_clk = ~user_clk;

   typedef struct packed {
      logic [127:0] dat;
      logic [3:0]   dwen;
      logic         first;
      logic         last;
      logic         err;
      logic [7:0]   tag;
   } beat_t;

   beat_t        got_q[$];
   beat_t        exp_q[$];
   int           cyc_q[$];
   int           n_chk = 0;
   int           n_fail = 0;
   int           cyc = 0;
   bit           ready_toggle = 1'b0;
   bit           stall_prev = 1'b0;
   logic [190:0] snap, snap_prev;

   task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   always @(posedge user_clk) cyc++;

   initial begin
      m_tready = 1'b1;
      forever begin
         @(posedge user_clk);
         #1;
         m_tready = ready_toggle ? ~m_tready : 1'b1;
      end
   end

   // Capture accepted beats and require every output to hold across a stalled edge
   always @(negedge user_clk) begin
      snap = {m_tdata, m_tdwen, m_tfirst, m_tlast, m_terr, cpl_tag, cpl_len, cpl_byte_count,
              cpl_lower_addr, cpl_status, cpl_cmp_id};
      if (stall_prev) check_val("stall_hold", {65'h0, snap}, {65'h0, snap_prev});
      stall_prev = m_tvalid && !m_tready && user_reset_n;
      snap_prev  = snap;
      if (m_tvalid === 1'b1 && m_tready === 1'b1) begin
         got_q.push_back('{m_tdata, m_tdwen, m_tfirst, m_tlast, m_terr, cpl_tag});
         cyc_q.push_back(cyc);
      end
   end

   function automatic logic [31:0] pdw(input int n, input logic [31:0] base, input int k);
      return (k < n) ? base + 32'(k) : 32'h0;
   endfunction

   function automatic logic [127:0] make_hdr(input int n, input logic [31:0] base,
                                             input logic [7:0] tag, input logic data);
      logic [31:0] dw0, dw1, dw2;
      dw0 = {(data ? 8'h4A : 8'h0A), 14'h0, 10'(n)};
      dw1 = {16'hBEEF, 3'b000, 1'b0, 12'(n * 4)};
      dw2 = {16'h0000, tag, 1'b0, 7'h10};
      return {(data ? pdw(n, base, 0) : 32'h0), dw2, dw1, dw0};
   endfunction

   task automatic drive_beat(input logic [127:0] d, input logic last, input logic [84:0] u);
      int t = 0;
      s_tvalid = 1'b1;
      s_tdata  = d;
      s_tlast  = last;
      s_tuser  = u;
      s_tkeep  = 16'hFFFF;
      @(negedge user_clk);
      while (!s_tready && t < 1000) begin
         @(negedge user_clk);
         t++;
      end
      if (!s_tready) check_val("s_tready_timeout", {255'h0, s_tready}, 256'h1);
      @(posedge user_clk);
      #1;
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
   endtask

   task automatic send_pkt(input int n, input logic [31:0] base, input logic [7:0] tag,
                           input logic data, input logic poison, input logic early);
      int nb;
      logic [127:0] d;
      nb = data ? 1 + (n + 2) / 4 : 1;
      if (early) nb = nb - 1;
      for (int b = 0; b < nb; b++) begin
         if (b == 0) begin
            drive_beat(make_hdr(n, base, tag, data), (nb == 1), {70'h0, 1'b1, 12'h0, poison, 1'b0});
         end else begin
            d = {pdw(n, base, 4*b), pdw(n, base, 4*b-1), pdw(n, base, 4*b-2), pdw(n, base, 4*b-3)};
            drive_beat(d, (b == nb - 1), 85'h0);
         end
      end
   endtask

   task automatic exp_clean(input int n, input logic [31:0] base, input logic [7:0] tag);
      int nbo;
      beat_t e;
      nbo = (n + 3) / 4;
      for (int j = 0; j < nbo; j++) begin
         e = '0;
         for (int k = 0; k < 4; k++) begin
            if (4*j + k < n) begin
               e.dat[32*k +: 32] = base + 32'(4*j + k);
               e.dwen[k] = 1'b1;
            end
         end
         e.first = (j == 0);
         e.last  = (j == nbo - 1);
         e.tag   = tag;
         exp_q.push_back(e);
      end
   endtask

   task automatic wait_out(input int n);
      int t = 0;
      while (got_q.size() < n && t < 3000) begin
         @(posedge user_clk);
         t++;
      end
      repeat (5) @(posedge user_clk);
      #1;
   endtask

   task automatic compare_q(input string name);
      check_val({name, "_count"}, 256'(got_q.size()), 256'(exp_q.size()));
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
         check_val(name, {113'h0, got_q[i]}, {113'h0, exp_q[i]});
      got_q.delete();
      exp_q.delete();
      cyc_q.delete();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge user_clk);
      @(negedge user_clk);
      check_val("rst_m_tvalid", {255'h0, m_tvalid}, 256'h0);
      check_val("rst_flags", {252'h0, m_tfirst, m_tlast, m_terr, 1'b0}, 256'h0);
      check_val("rst_m_tdwen", {252'h0, m_tdwen}, 256'h0);
      check_val("rst_m_tdata", {128'h0, m_tdata}, 256'h0);
      check_val("rst_cpl_tag", {248'h0, cpl_tag}, 256'h0);
      check_val("rst_s_tready", {255'h0, s_tready}, 256'h1);
      @(posedge user_clk);
      #1;
      user_reset_n = 1'b1;

      send_pkt(1, 32'hA5A5A5A5, 8'h3C, 1'b1, 1'b0, 1'b0);
      exp_clean(1, 32'hA5A5A5A5, 8'h3C);
      wait_out(1);
      compare_q("len1");
      check_val("len1_cpl_len", {246'h0, cpl_len}, 256'd1);
      check_val("len1_byte_count", {244'h0, cpl_byte_count}, 256'd4);
      check_val("len1_lower_addr", {249'h0, cpl_lower_addr}, 256'h10);
      check_val("len1_cmp_id", {240'h0, cpl_cmp_id}, 256'hBEEF);
      check_val("len1_status", {253'h0, cpl_status}, 256'h0);

      send_pkt(4, 32'h10000000, 8'h11, 1'b1, 1'b0, 1'b0);
      exp_clean(4, 32'h10000000, 8'h11);
      wait_out(1);
      compare_q("len4");

      send_pkt(5, 32'h20000000, 8'h22, 1'b1, 1'b0, 1'b0);
      exp_clean(5, 32'h20000000, 8'h22);
      wait_out(2);
      compare_q("len5");

      send_pkt(1024, 32'h40000000, 8'h44, 1'b1, 1'b0, 1'b0);
      exp_clean(1024, 32'h40000000, 8'h44);
      wait_out(256);
      if (cyc_q.size() == 256)
         check_val("len1024_span", 256'(cyc_q[255] - cyc_q[0]), 256'd255);
      compare_q("len1024");

      ready_toggle = 1'b1;
      send_pkt(8, 32'h50000000, 8'h55, 1'b1, 1'b0, 1'b0);
      exp_clean(8, 32'h50000000, 8'h55);
      wait_out(2);
      ready_toggle = 1'b0;
      repeat (2) @(posedge user_clk);
      #1;
      compare_q("len8_stall");

      send_pkt(2, 32'h60000000, 8'h66, 1'b1, 1'b1, 1'b0);
      send_pkt(3, 32'h70000000, 8'h77, 1'b1, 1'b0, 1'b1);
      send_pkt(4, 32'h80000000, 8'h88, 1'b1, 1'b0, 1'b0);
      exp_q.push_back('{{64'h0, 32'h60000001, 32'h60000000}, 4'b0011, 1'b1, 1'b1, 1'b1, 8'h66});
      exp_q.push_back('{128'h0, 4'b0000, 1'b1, 1'b1, 1'b1, 8'h77});
      exp_clean(4, 32'h80000000, 8'h88);
      wait_out(3);
      compare_q("err_seq");

      send_pkt(1, 32'h0, 8'h99, 1'b0, 1'b0, 1'b0);
      exp_q.push_back('{128'h0, 4'b0000, 1'b1, 1'b1, 1'b0, 8'h99});
      wait_out(1);
      compare_q("nodata");

      drive_beat(make_hdr(8, 32'h90000000, 8'h9A, 1'b1), 1'b0, 85'h4000);
      drive_beat({32'h90000004, 32'h90000003, 32'h90000002, 32'h90000001}, 1'b0, 85'h0);
      user_reset_n = 1'b0;
      @(negedge user_clk);
      @(negedge user_clk);
      check_val("midrst_m_tvalid", {255'h0, m_tvalid}, 256'h0);
      @(posedge user_clk);
      #1;
      user_reset_n = 1'b1;
      got_q.delete();
      cyc_q.delete();
      drive_beat(128'hDEAD, 1'b1, 85'h0);
      send_pkt(5, 32'hAA000000, 8'hAA, 1'b1, 1'b0, 1'b0);
      exp_clean(5, 32'hAA000000, 8'hAA);
      wait_out(2);
      compare_q("after_rst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
